// File: rtl/sun_pll_ctrl.sv
// Power-up sequencer and frequency lock monitor for the SUN_PLL analog core.
// Counts synchronized FB_DIV8 edges over fixed reference windows and tracks lock/timeout.
module sun_pll_ctrl #(
  parameter int T_BIAS   = 64,
  parameter int T_KICK   = 8,
  parameter int WIN_LOG2 = 8,
  parameter int EXP_CNT  = 32,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int MAX_WIN  = 64
) (
  input  logic       CK_REF,
  input  logic       RST,
  input  logic       EN,
  input  logic       FB_DIV8,
  output logic       PWRUP_BIAS,
  output logic       PWRUP_1V8,
  output logic       KICK,
  output logic       LOCKED,
  output logic       FAIL,
  output logic [2:0] STATE,
  output logic [7:0] FB_COUNT
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_BIAS = 3'd1,
    S_KICK = 3'd2,
    S_ACQ  = 3'd3,
    S_LOCK = 3'd4,
    S_FAIL = 3'd5
  } state_t;

  localparam int PH_W = $clog2((T_BIAS > T_KICK) ? T_BIAS : T_KICK) + 1;
  localparam int GC_W = $clog2(LOCK_CNT + 1);
  localparam int WC_W = $clog2(MAX_WIN + 1);

  localparam logic [PH_W-1:0]     BIAS_LAST = PH_W'(T_BIAS - 1);
  localparam logic [PH_W-1:0]     KICK_LAST = PH_W'(T_KICK - 1);
  localparam logic [GC_W-1:0]     GOOD_TGT  = GC_W'(LOCK_CNT);
  localparam logic [WC_W-1:0]     WIN_TGT   = WC_W'(MAX_WIN);
  localparam logic [WIN_LOG2-1:0] WIN_LAST  = '1;
  localparam logic signed [9:0]   EXP_S     = 10'(EXP_CNT);
  localparam logic signed [9:0]   TOL_S     = 10'(TOL);

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic p);
    return (p && (c != 8'hFF)) ? c + 8'd1 : c;
  endfunction

  function automatic logic in_tol(input logic [7:0] c);
    logic signed [9:0] d;
    d = $signed({2'b00, c}) - EXP_S;
    return (d >= -TOL_S) && (d <= TOL_S);
  endfunction

  state_t              state, state_n;
  logic [PH_W-1:0]     ph_cnt, ph_n;
  logic [WIN_LOG2-1:0] wtmr, wtmr_n;
  logic [7:0]          ecnt, ecnt_n;
  logic [GC_W-1:0]     gcnt, gcnt_n;
  logic [WC_W-1:0]     wcnt, wcnt_n;
  logic [7:0]          fbc_n;
  logic                fb_p0, fb_p1, fb_p2;
  logic                pulse, win_end, good;
  logic [7:0]          cnt_final;

  // Stage p0/p1: two-flop synchronizer; p2: previous value for rising-edge detect
  assign pulse     = fb_p1 & ~fb_p2;
  assign win_end   = ((state == S_ACQ) || (state == S_LOCK)) && (wtmr == WIN_LAST);
  assign cnt_final = sat_inc(ecnt, pulse);
  assign good      = in_tol(cnt_final);

  always_comb begin
    state_n = state;
    ph_n    = ph_cnt + 1'b1;
    wtmr_n  = wtmr + 1'b1;
    ecnt_n  = cnt_final;
    gcnt_n  = gcnt;
    wcnt_n  = wcnt;
    fbc_n   = FB_COUNT;
    case (state)
      S_OFF: begin
        ph_n = '0;
        if (EN) state_n = S_BIAS;
      end
      S_BIAS: begin
        if (ph_cnt == BIAS_LAST) begin
          state_n = S_KICK;
          ph_n    = '0;
        end
      end
      S_KICK: begin
        if (ph_cnt == KICK_LAST) begin
          state_n = S_ACQ;
          wtmr_n  = '0;
          ecnt_n  = '0;
          gcnt_n  = '0;
          wcnt_n  = '0;
        end
      end
      S_ACQ: begin
        if (win_end) begin
          fbc_n  = cnt_final;
          ecnt_n = '0;
          gcnt_n = good ? gcnt + 1'b1 : '0;
          wcnt_n = wcnt + 1'b1;
          // Lock takes priority over timeout when both land on the same window
          if (good && ((gcnt + 1'b1) == GOOD_TGT)) state_n = S_LOCK;
          else if ((wcnt + 1'b1) == WIN_TGT)       state_n = S_FAIL;
        end
      end
      S_LOCK: begin
        if (win_end) begin
          fbc_n  = cnt_final;
          ecnt_n = '0;
          if (!good) begin
            state_n = S_ACQ;
            gcnt_n  = '0;
            wcnt_n  = '0;
          end
        end
      end
      S_FAIL: ;
      default: state_n = S_OFF;
    endcase
    if (!EN) state_n = S_OFF;
    if (state_n == S_OFF) fbc_n = '0;
  end

  // Stage boundary: state, counters and decoded outputs all register on the same edge
  always_ff @(posedge CK_REF) begin
    if (RST) begin
      state      <= S_OFF;
      ph_cnt     <= '0;
      wtmr       <= '0;
      ecnt       <= '0;
      gcnt       <= '0;
      wcnt       <= '0;
      fb_p0      <= 1'b0;
      fb_p1      <= 1'b0;
      fb_p2      <= 1'b0;
      PWRUP_BIAS <= 1'b0;
      PWRUP_1V8  <= 1'b0;
      KICK       <= 1'b0;
      LOCKED     <= 1'b0;
      FAIL       <= 1'b0;
      FB_COUNT   <= '0;
    end else begin
      state      <= state_n;
      ph_cnt     <= ph_n;
      wtmr       <= wtmr_n;
      ecnt       <= ecnt_n;
      gcnt       <= gcnt_n;
      wcnt       <= wcnt_n;
      fb_p0      <= FB_DIV8;
      fb_p1      <= fb_p0;
      fb_p2      <= fb_p1;
      PWRUP_BIAS <= state_n inside {S_BIAS, S_KICK, S_ACQ, S_LOCK, S_FAIL};
      PWRUP_1V8  <= state_n inside {S_KICK, S_ACQ, S_LOCK};
      KICK       <= (state_n == S_KICK);
      LOCKED     <= (state_n == S_LOCK);
      FAIL       <= (state_n == S_FAIL);
      FB_COUNT   <= fbc_n;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// Directed + randomized bench for sun_pll_ctrl with a window-level lock/timeout model.
module tb_sun_pll_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, fb;
  logic       pwrup_bias, pwrup_1v8, kick, locked, fail;
  logic [2:0] state;
  logic [7:0] fb_count;
  logic       en2, fb2;
  logic       pwrup_bias_s, pwrup_1v8_s, kick_s, locked_s, fail_s;
  logic [2:0] state_s;
  logic [7:0] fb_count_s;

  int vectors = 0;
  int miscompares = 0;

  // model: mode 0=ACQ 1=LOCK 2=FAIL
  int m_mode, m_streak, m_wins;

  always #5 clk = ~clk;

  sun_pll_ctrl u_dut (
    .CK_REF(clk), .RST(rst), .EN(en), .FB_DIV8(fb),
    .PWRUP_BIAS(pwrup_bias), .PWRUP_1V8(pwrup_1v8), .KICK(kick),
    .LOCKED(locked), .FAIL(fail), .STATE(state), .FB_COUNT(fb_count)
  );

  sun_pll_ctrl #(.WIN_LOG2(10)) u_sat (
    .CK_REF(clk), .RST(rst), .EN(en2), .FB_DIV8(fb2),
    .PWRUP_BIAS(pwrup_bias_s), .PWRUP_1V8(pwrup_1v8_s), .KICK(kick_s),
    .LOCKED(locked_s), .FAIL(fail_s), .STATE(state_s), .FB_COUNT(fb_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {17'd0, pwrup_bias, pwrup_1v8, kick, locked, fail, state, fb_count}, 32'd0);
  endtask

  // EN rises just after edge 0; checks the power-up timeline through ACQ entry at edge 73
  task automatic startup();
    en = 1'b1;
    for (int i = 1; i <= 73; i++) begin
      cyc();
      if (i == 1 || i == 64) begin
        chk($sformatf("bias_c%0d", i), {pwrup_bias, pwrup_1v8, kick, state}, {3'b100, 3'd1});
      end
      if (i == 65 || i == 72) begin
        chk($sformatf("kick_c%0d", i), {pwrup_bias, pwrup_1v8, kick, state}, {3'b111, 3'd2});
      end
      if (i == 73) begin
        chk("acq_entry", {pwrup_bias, pwrup_1v8, kick, state}, {3'b110, 3'd3});
      end
    end
    m_mode = 0; m_streak = 0; m_wins = 0;
  endtask

  // One 256-cycle window with n FB rising edges placed clear of the window boundaries
  task automatic win(input int n, input string tag);
    int  exp_cnt;
    bit  good;
    for (int j = 0; j < 256; j++) begin
      fb = (j >= 20) && (j < 20 + 4 * n) && (((j - 20) % 4) < 2);
      cyc();
    end
    fb = 1'b0;
    exp_cnt = (n > 255) ? 255 : n;
    good = (n >= 32 - 2) && (n <= 32 + 2);
    if (m_mode == 0) begin
      m_wins++;
      m_streak = good ? m_streak + 1 : 0;
      if (m_streak == 4)     m_mode = 1;
      else if (m_wins == 64) m_mode = 2;
    end else if (m_mode == 1 && !good) begin
      m_mode = 0; m_streak = 0; m_wins = 0;
    end
    chk({tag, "_count"},  fb_count, exp_cnt);
    chk({tag, "_locked"}, locked, (m_mode == 1));
    chk({tag, "_fail"},   fail, (m_mode == 2));
    chk({tag, "_state"},  state, (m_mode == 0) ? 3 : (m_mode == 1) ? 4 : 5);
  endtask

  initial begin
    int seq[7];
    rst = 1'b1; en = 1'b0; fb = 1'b0; en2 = 1'b0; fb2 = 1'b0;
    cyc(); cyc(); cyc();
    chk_zero("reset");
    chk("reset_sat", {fb_count_s, state_s}, 0);
    rst = 1'b0;
    cyc();
    chk_zero("idle_off");

    startup();
    for (int k = 0; k < 4; k++) win(32, $sformatf("nom%0d", k));

    win(40, "lol");
    for (int k = 0; k < 4; k++) win(30 + $urandom_range(0, 4), $sformatf("relock%0d", k));

    win(30, "tol30");
    win(34, "tol34");
    win(29, "tol29");
    seq = '{32, 32, 35, 32, 32, 32, 32};
    for (int k = 0; k < 7; k++) win(seq[k], $sformatf("tolseq%0d", k));

    for (int k = 0; k < 16; k++) win($urandom_range(27, 37), $sformatf("rnd%0d", k));
    for (int k = 0; k < 4; k++) win(32, $sformatf("lock%0d", k));

    for (int j = 0; j < 50; j++) cyc();
    chk("pre_rst_locked", locked, 1);
    rst = 1'b1; en = 1'b0;
    cyc();
    chk_zero("rst_in_lock");
    rst = 1'b0;
    cyc();

    en = 1'b1;
    for (int j = 0; j < 66; j++) cyc();
    chk("pre_rst_kick", {kick, state}, {1'b1, 3'd2});
    rst = 1'b1; en = 1'b0;
    cyc();
    chk_zero("rst_in_kick");
    rst = 1'b0;
    cyc();

    en = 1'b1;
    for (int j = 0; j < 10; j++) cyc();
    chk("pre_en_bias", {pwrup_bias, state}, {1'b1, 3'd1});
    en = 1'b0;
    cyc();
    chk_zero("en_drop_bias");

    startup();
    for (int k = 0; k < 64; k++) win(0, $sformatf("tmo%0d", k));
    for (int j = 0; j < 20; j++) cyc();
    chk("fail_hold", {pwrup_bias, pwrup_1v8, kick, locked, fail, state}, {5'b10001, 3'd5});
    en = 1'b0;
    cyc();
    chk_zero("fail_en_low");

    en2 = 1'b1;
    for (int j = 0; j < 73; j++) cyc();
    chk("sat_acq", state_s, 3);
    for (int j = 0; j < 1024; j++) begin
      fb2 = (j >= 10) && (j < 610) && (j % 2 == 1);
      cyc();
    end
    fb2 = 1'b0;
    chk("sat_count", fb_count_s, 255);
    chk("sat_state", state_s, 3);
    en2 = 1'b0;
    cyc();
    chk("sat_off", {fb_count_s, state_s}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
